// File: rtl/rom_loader.sv
// rom_loader: receives a framed program image over a byte stream
// (4-byte LE word count, 4*N LE data bytes, 8-bit additive checksum)
// and writes it word-by-word into the instruction ROM, holding the
// core in halt for the duration of the load.
module rom_loader #(
   parameter int ROM_WORDS = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic        rx_valid_i,
   input  logic [7:0]  rx_data_i,
   output logic        rx_ready_o,
   output logic        rom_we_o,
   output logic [31:0] rom_addr_o,
   output logic [31:0] rom_data_o,
   output logic        core_halt_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o
);

   localparam int          IDX_W   = $clog2(ROM_WORDS) + 1;
   localparam logic [31:0] MAX_LEN = 32'(ROM_WORDS);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
   } state_t;

   state_t             state, state_nxt;
   logic [31:0]        len_q, len_nxt;
   logic [31:0]        word_q, word_nxt;
   logic [1:0]         byte_cnt;
   logic [IDX_W-1:0]   word_idx, word_idx_inc;
   logic [7:0]         csum_q;
   logic               accept;
   logic               last_byte;
   logic               start_ok;

   // Ready is a pure state decode so there is no path from rx_valid_i.
   assign rx_ready_o   = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
   assign accept       = rx_valid_i && rx_ready_o;
   assign last_byte    = accept && (byte_cnt == 2'd3);
   assign start_ok     = (state == S_IDLE) && start_i;
   assign word_idx_inc = word_idx + IDX_W'(1);
   assign core_halt_o  = busy_o;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Next-state decode plus byte-merged views of the length/word registers.
   always_comb begin
      state_nxt = state;
      len_nxt   = len_q;
      word_nxt  = word_q;
      len_nxt[{byte_cnt, 3'b000} +: 8]  = rx_data_i;
      word_nxt[{byte_cnt, 3'b000} +: 8] = rx_data_i;
      case (state)
         S_IDLE:  if (start_i) state_nxt = S_LEN;
         S_LEN: begin
            if (last_byte) begin
               if (len_nxt > MAX_LEN)    state_nxt = S_ERR;
               else if (len_nxt == '0)   state_nxt = S_CSUM;
               else                      state_nxt = S_DATA;
            end
         end
         S_DATA:  if (last_byte) state_nxt = S_WRITE;
         S_WRITE: state_nxt = (32'(word_idx_inc) == len_q) ? S_CSUM : S_DATA;
         S_CSUM:  if (accept) state_nxt = (rx_data_i == csum_q) ? S_DONE : S_ERR;
         S_DONE:  state_nxt = S_IDLE;
         S_ERR:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Datapath counters, checksum and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         len_q      <= '0;
         word_q     <= '0;
         byte_cnt   <= '0;
         word_idx   <= '0;
         csum_q     <= '0;
         rom_we_o   <= 1'b0;
         rom_addr_o <= '0;
         rom_data_o <= '0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         err_o      <= 1'b0;
      end else begin
         if (start_ok) begin
            byte_cnt <= '0;
            word_idx <= '0;
            csum_q   <= '0;
         end
         if (accept && state == S_LEN) begin
            len_q    <= len_nxt;
            byte_cnt <= byte_cnt + 2'd1;
         end
         if (accept && state == S_DATA) begin
            word_q   <= word_nxt;
            csum_q   <= csum_q + rx_data_i;
            byte_cnt <= byte_cnt + 2'd1;
         end
         if (state == S_WRITE) word_idx <= word_idx_inc;

         // Outputs are decoded from the next state so they line up with it.
         rom_we_o <= (state_nxt == S_WRITE);
         if (state_nxt == S_WRITE) begin
            rom_addr_o <= 32'(word_idx) << 2;
            rom_data_o <= word_nxt;
         end
         busy_o <= (state_nxt != S_IDLE);
         done_o <= (state_nxt == S_DONE);
         if (state_nxt == S_ERR) err_o <= 1'b1;
         else if (start_ok)      err_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rom_loader.sv
// Testbench for rom_loader: a frame-level reference model queues the
// expected ROM writes and completion/error events; a monitor pops and
// compares them as the DUT presents them.
module tb_rom_loader;

   localparam int RW = 16;
   localparam int K_WR = 0, K_DONE = 1, K_ERR = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start_i = 1'b0;
   logic        rx_valid_i = 1'b0;
   logic [7:0]  rx_data_i = 8'h00;
   logic        rx_ready_o, rom_we_o, core_halt_o, busy_o, done_o, err_o;
   logic [31:0] rom_addr_o, rom_data_o;

   rom_loader #(.ROM_WORDS(RW)) dut (
      .clk(clk), .rst(rst), .start_i(start_i),
      .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i), .rx_ready_o(rx_ready_o),
      .rom_we_o(rom_we_o), .rom_addr_o(rom_addr_o), .rom_data_o(rom_data_o),
      .core_halt_o(core_halt_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic [31:0] data;
   } ev_t;

   ev_t         exp_q[$];
   logic [31:0] img[$];
   int          total = 0;
   int          bad = 0;
   logic        err_prev = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic push_ev(input int kind, input logic [31:0] a, input logic [31:0] d);
      ev_t e;
      e.kind = kind; e.addr = a; e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic pop_cmp(input int kind, input logic [31:0] a, input logic [31:0] d);
      ev_t e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL event: got kind=%0d addr=%h data=%h want no event", kind, a, d);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.addr !== a || e.data !== d) begin
            bad++;
            $display("FAIL event: got kind=%0d addr=%h data=%h want kind=%0d addr=%h data=%h",
                     kind, a, d, e.kind, e.addr, e.data);
         end
      end
   endtask

   // Monitor: every DUT-presented write / done / new error is scored.
   always @(negedge clk) begin
      if (rst) begin
         if (rom_we_o) begin
            chk("ready_in_write", {31'b0, rx_ready_o}, 32'd0);
            pop_cmp(K_WR, rom_addr_o, rom_data_o);
         end
         if (done_o) pop_cmp(K_DONE, 32'd0, 32'd0);
         if (err_o && !err_prev) pop_cmp(K_ERR, 32'd0, 32'd0);
      end
      err_prev = err_o;
   end

   task automatic check_reset_vals(input string tag);
      chk({tag, "_ready"}, {31'b0, rx_ready_o}, 32'd0);
      chk({tag, "_we"},    {31'b0, rom_we_o},   32'd0);
      chk({tag, "_addr"},  rom_addr_o,          32'd0);
      chk({tag, "_data"},  rom_data_o,          32'd0);
      chk({tag, "_halt"},  {31'b0, core_halt_o}, 32'd0);
      chk({tag, "_busy"},  {31'b0, busy_o},     32'd0);
      chk({tag, "_done"},  {31'b0, done_o},     32'd0);
      chk({tag, "_err"},   {31'b0, err_o},      32'd0);
   endtask

   task automatic do_start();
      start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      chk("start_err_clr", {31'b0, err_o},       32'd0);
      chk("start_busy",    {31'b0, busy_o},      32'd1);
      chk("start_halt",    {31'b0, core_halt_o}, 32'd1);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int w;
      bit got;
      if (gaps && $urandom_range(0, 2) == 0) begin
         rx_valid_i = 1'b0;
         repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      rx_valid_i = 1'b1;
      rx_data_i  = b;
      got = 1'b0;
      w = 0;
      while (!got && w < 200) begin
         got = rx_ready_o;
         @(posedge clk); #1;
         w++;
      end
      if (!got) begin
         total++; bad++;
         $display("FAIL byte_timeout: got ready=0 want ready=1");
      end
   endtask

   task automatic wait_idle();
      int cyc = 0;
      while (busy_o && cyc < 500) begin @(posedge clk); #1; cyc++; end
      chk("idle_reached", {31'b0, busy_o}, 32'd0);
   endtask

   // Reference model + stimulus for one frame; uses img[] as the payload.
   task automatic run_frame(input logic [31:0] n, input logic [7:0] delta,
                            input bit gaps, input bit poke);
      logic [7:0]  bytes[$];
      logic [7:0]  sum = 8'h00;
      logic [31:0] w;
      bit          fail;
      fail = (n > RW) || (delta != 8'h00);
      for (int i = 0; i < 4; i++) bytes.push_back(n[8*i +: 8]);
      if (n <= RW) begin
         for (int k = 0; k < img.size(); k++) begin
            w = img[k];
            for (int i = 0; i < 4; i++) begin
               bytes.push_back(w[8*i +: 8]);
               sum = sum + w[8*i +: 8];
            end
            push_ev(K_WR, 32'(k) * 4, w);
         end
         bytes.push_back(sum + delta);
         push_ev(delta == 8'h00 ? K_DONE : K_ERR, 32'd0, 32'd0);
      end else begin
         push_ev(K_ERR, 32'd0, 32'd0);
      end

      do_start();
      for (int i = 0; i < bytes.size(); i++) begin
         if (poke && i == 5) begin
            rx_valid_i = 1'b0;
            start_i = 1'b1;
            @(posedge clk); #1;
            start_i = 1'b0;
         end
         send_byte(bytes[i], gaps);
      end
      rx_valid_i = 1'b0;
      if (n > RW) begin
         chk("oversize_err",   {31'b0, err_o},      32'd1);
         chk("oversize_ready", {31'b0, rx_ready_o}, 32'd0);
      end
      if (poke) begin
         start_i = 1'b1;
         @(posedge clk); #1;
         start_i = 1'b0;
         chk("start_at_end_ignored", {31'b0, busy_o}, 32'd0);
      end
      wait_idle();
      chk("end_ready", {31'b0, rx_ready_o},  32'd0);
      chk("end_halt",  {31'b0, core_halt_o}, 32'd0);
      chk("end_err",   {31'b0, err_o},       {31'b0, fail});
      chk("end_queue", 32'(exp_q.size()),    32'd0);
   endtask

   initial begin
      logic [31:0] n;
      logic [7:0]  d;

      repeat (2) @(posedge clk);
      #1;
      check_reset_vals("reset");
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;

      // Good frame, then same frame with bad checksum.
      img = '{32'h0000_0013, 32'h0000_006F};
      run_frame(32'd2, 8'h00, 1'b0, 1'b0);
      run_frame(32'd2, 8'h01, 1'b0, 1'b0);

      // Zero length, good and bad checksum.
      img = {};
      run_frame(32'd0, 8'h00, 1'b0, 1'b0);
      run_frame(32'd0, 8'h01, 1'b0, 1'b0);

      // Oversize and exactly full.
      run_frame(32'(RW + 1), 8'h00, 1'b0, 1'b0);
      img = {};
      for (int k = 0; k < RW; k++) img.push_back($urandom);
      run_frame(32'(RW), 8'h00, 1'b0, 1'b0);

      // Backpressure with start pulses while busy and in DONE.
      img = '{32'h0000_0013, 32'h0000_006F};
      run_frame(32'd2, 8'h00, 1'b1, 1'b1);

      // A waiting byte in IDLE is not accepted.
      rx_valid_i = 1'b1; rx_data_i = 8'hA5;
      @(posedge clk); #1;
      chk("idle_ready", {31'b0, rx_ready_o}, 32'd0);
      rx_valid_i = 1'b0;

      // Reset after the first word is written.
      img = '{32'hDEAD_BEEF, 32'h1234_5678, 32'h0BAD_F00D};
      push_ev(K_WR, 32'd0, img[0]);
      do_start();
      for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'd3 : 8'd0, 1'b0);
      n = img[0];
      for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], 1'b0);
      rx_valid_i = 1'b0;
      @(negedge clk); #1;
      rst = 1'b0;
      #1;
      check_reset_vals("async_rst");
      @(posedge clk); #1;
      chk("rst_held_busy", {31'b0, busy_o}, 32'd0);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_queue", 32'(exp_q.size()), 32'd0);
      img = '{32'h0000_0013, 32'h0000_006F};
      run_frame(32'd2, 8'h00, 1'b0, 1'b0);

      // Randomized frames.
      for (int t = 0; t < 10; t++) begin
         n = 32'($urandom_range(0, 6));
         img = {};
         for (int k = 0; k < int'(n); k++) img.push_back($urandom);
         d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         run_frame(n, d, 1'b1, t[0]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
